csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
Machine-mode CSR file and trap sequencer that sits directly downstream of the ALU's CSR port. It holds the supported M-mode CSRs and provides a combinational read for the ALU's CSR instructions. It commits the ALU-computed CSR write data at the clock edge. It sequences ecall/mret, issuing a registered one-cycle PC redirect to the fetch stage.

Parameters:
MTVEC_RESET, 64'h0, reset value of mtvec; bits [1:0] forced to 0.
HART_ID, 64'h0, value returned by mhartid.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
csr_rd_addr  in  12  CSR read address from ALU
csr_rd_data  out  64  combinational read data
csr_wr_addr  in  12  CSR write address from ALU
csr_wr_data  in  64  final write value computed by ALU (rw/rs/rc already applied)
csr_wr_en  in  1  write strobe
ecall_valid  in  1  ecall retiring this cycle
mret_valid  in  1  mret retiring this cycle
pc  in  64  PC of the retiring instruction
redirect_valid  out  1  one-cycle redirect pulse to fetch
redirect_pc  out  64  redirect target
csr_illegal  out  1  combinational: unsupported read address, or write to unsupported/read-only CSR

Behaviour:
- Supported CSRs:
  - mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] are implemented; other bits read 0.
  - mtvec 0x305: direct mode only; bits [1:0] are written as 0.
  - mscratch 0x340: full 64 bits.
  - mepc 0x341: bit 0 is written as 0.
  - mcause 0x342: full 64 bits.
  - mcycle 0xB00: read/write.
  - mhartid 0xF14: read-only, returns HART_ID.
- Read: combinational from current register state; a same-cycle write is not forwarded. An unsupported address returns 0 and raises csr_illegal.
- Write: takes effect at the posedge when csr_wr_en=1.
  - Unsupported address, or csr_wr_addr[11:10]==2'b11: write ignored, csr_illegal=1.
- mcycle: increments by 1 every cycle and wraps 2^64-1 -> 0. In a cycle with a software write to mcycle, the written value is loaded and there is no increment.
- ecall (cycle N) -> at posedge ending N:
  - mepc <= {pc[63:1],1'b0}
  - mcause <= 64'd11
  - mstatus.MPIE <= MIE; MIE <= 0; MPP <= 2'b11
  - During N+1: redirect_valid=1, redirect_pc = mtvec value held during N.
- mret (cycle N) -> at posedge:
  - mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b00
  - During N+1: redirect_valid=1, redirect_pc = mepc value held during N.
- Priority for simultaneous events: ecall > mret > csr_wr_en.
  - The losing CSR write is dropped entirely.
  - mcycle still increments.
- redirect_valid is a single-cycle pulse. Back-to-back ecall/mret produce back-to-back pulses.
- Reset (rst=0 at posedge), including mid-sequence:
  - All CSRs are 0, except mtvec=MTVEC_RESET & ~64'h3.
  - redirect_valid=0, redirect_pc=0.
  - A pending redirect is cancelled.
  - ecall_valid, mret_valid and csr_wr_en are ignored in the reset cycle.
- Latency: read 0 cycles; write 1 cycle; redirect 1 cycle.

Decomposition:
- csr_pkg holds the shared constants:
  - CSR addresses: 0x300, 0x305, 0x340, 0x341, 0x342, 0xB00, 0xF14.
  - mstatus bit positions: MIE=3, MPIE=7, MPP=12:11.
  - Cause code CAUSE_ECALL_M=11.
- Sub-module: csr_trap_ctrl, covering the ecall/mret priority, mstatus update and redirect register.
- The CSR storage and read mux stay in the top-level module.

Test Plan:
1. Reset then read: rst=0 for 2 cycles, MTVEC_RESET=64'h8000_0003; read 0x305 -> 64'h8000_0000; read 0x341 -> 0; redirect_valid=0.
2. Write/readback: write 0x340=64'hDEAD_BEEF_0123_4567 -> next cycle reads the same value. Write 0xF14=5 -> csr_illegal=1 and mhartid still reads HART_ID. Read 0x7C0 -> data 0 and csr_illegal=1.
3. ecall: mtvec=64'h8000_1000, MIE=1, pc=64'h8000_0204, ecall_valid=1 -> next cycle:
   - redirect_valid=1, redirect_pc=64'h8000_1000
   - mepc=64'h8000_0204, mcause=11
   - mstatus reads 64'h1880
   - The cycle after: redirect_valid=0.
4. mret after step 3: mret_valid=1 -> next cycle redirect_pc=64'h8000_0204, mstatus=64'h88.
5. Simultaneous events: ecall_valid=1, mret_valid=1 and csr_wr_en=1 to mscratch=7 in the same cycle -> the ecall path is taken, mscratch is unchanged, mret has no effect.
6. mcycle: write 0xB00=64'hFFFF_FFFF_FFFF_FFFE -> readback shows that value, then ...FFFF one cycle later, then 0 the cycle after (wrap). Assert rst mid-ecall, in cycle N+1 before the pulse is sampled -> redirect_valid=0 the following cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, mstatus bit positions and cause codes
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

    // Which retirement event the trap sequencer acts on this cycle
    typedef enum logic [1:0] {
        TRAP_NONE  = 2'd0,
        TRAP_ECALL = 2'd1,
        TRAP_MRET  = 2'd2
    } trap_e;

    function automatic logic csr_supported(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MCYCLE, CSR_MHARTID: csr_supported = 1'b1;
            default:                             csr_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// rtl/csr_trap_unit_if.sv - ALU CSR port and trap/redirect signals
interface csr_trap_unit_if;
    logic [11:0] csr_rd_addr;
    logic [63:0] csr_rd_data;
    logic [11:0] csr_wr_addr;
    logic [63:0] csr_wr_data;
    logic        csr_wr_en;
    logic        ecall_valid;
    logic        mret_valid;
    logic [63:0] pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        csr_illegal;

    modport master (
        output csr_rd_addr, csr_wr_addr, csr_wr_data, csr_wr_en,
        output ecall_valid, mret_valid, pc,
        input  csr_rd_data, redirect_valid, redirect_pc, csr_illegal
    );

    modport slave (
        input  csr_rd_addr, csr_wr_addr, csr_wr_data, csr_wr_en,
        input  ecall_valid, mret_valid, pc,
        output csr_rd_data, redirect_valid, redirect_pc, csr_illegal
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - ecall/mret priority, mstatus fields and redirect register
module csr_trap_ctrl
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_valid,
    input  logic        mret_valid,
    input  logic        mstatus_wr_en,
    input  logic [63:0] mstatus_wr_data,
    input  logic [63:0] mtvec,
    input  logic [63:0] mepc,
    output trap_e       trap_sel,
    output logic [63:0] mstatus,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [1:0]  mpp_q, mpp_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    // Select the winning event, update mstatus and latch the redirect target
    always_comb begin
        trap_sel         = TRAP_NONE;
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        mpp_d            = mpp_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (ecall_valid) begin
            trap_sel = TRAP_ECALL;
        end else if (mret_valid) begin
            trap_sel = TRAP_MRET;
        end

        case (trap_sel)
            TRAP_ECALL: begin
                mpie_d           = mie_q;
                mie_d            = 1'b0;
                mpp_d            = 2'b11;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mtvec;
            end
            TRAP_MRET: begin
                mie_d            = mpie_q;
                mpie_d           = 1'b1;
                mpp_d            = 2'b00;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mepc;
            end
            default: begin
                if (mstatus_wr_en) begin
                    mie_d  = mstatus_wr_data[MSTATUS_MIE];
                    mpie_d = mstatus_wr_data[MSTATUS_MPIE];
                    mpp_d  = mstatus_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                end
            end
        endcase
    end

    // Register mstatus fields and the one-cycle redirect; reset drops any pending pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            mpp_q            <= 2'b00;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'h0;
        end else begin
            mie_q            <= mie_d;
            mpie_q           <= mpie_d;
            mpp_q            <= mpp_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Assemble the architectural mstatus view; unimplemented bits read 0
    always_comb begin
        mstatus                                = 64'h0;
        mstatus[MSTATUS_MIE]                   = mie_q;
        mstatus[MSTATUS_MPIE]                  = mpie_q;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - M-mode CSR storage, read mux and trap sequencer top
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    parameter logic [63:0] HART_ID     = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    csr_trap_unit_if.slave  bus
);

    localparam logic [63:0] MTVEC_INIT = MTVEC_RESET & ~64'h3;

    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;

    logic [63:0] mstatus;
    trap_e       trap_sel;
    logic        wr_legal;
    logic        wr_accept;

    // Writes to unknown or read-only (addr[11:10]==11) CSRs never land;
    // a retiring ecall/mret also swallows the write entirely
    assign wr_legal  = csr_supported(bus.csr_wr_addr) && (bus.csr_wr_addr[11:10] != 2'b11);
    assign wr_accept = bus.csr_wr_en && wr_legal && (trap_sel == TRAP_NONE);

    csr_trap_ctrl u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .ecall_valid     (bus.ecall_valid),
        .mret_valid      (bus.mret_valid),
        .mstatus_wr_en   (wr_accept && (bus.csr_wr_addr == CSR_MSTATUS)),
        .mstatus_wr_data (bus.csr_wr_data),
        .mtvec           (mtvec_q),
        .mepc            (mepc_q),
        .trap_sel        (trap_sel),
        .mstatus         (mstatus),
        .redirect_valid  (bus.redirect_valid),
        .redirect_pc     (bus.redirect_pc)
    );

    // Next-state for CSR storage: software writes, trap side effects, free-running mcycle
    always_comb begin
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;

        if (wr_accept) begin
            case (bus.csr_wr_addr)
                CSR_MTVEC:    mtvec_d    = bus.csr_wr_data & ~64'h3;
                CSR_MSCRATCH: mscratch_d = bus.csr_wr_data;
                CSR_MEPC:     mepc_d     = bus.csr_wr_data & ~64'h1;
                CSR_MCAUSE:   mcause_d   = bus.csr_wr_data;
                CSR_MCYCLE:   mcycle_d   = bus.csr_wr_data;
                default:      ;
            endcase
        end

        if (trap_sel == TRAP_ECALL) begin
            mepc_d   = {bus.pc[63:1], 1'b0};
            mcause_d = CAUSE_ECALL_M;
        end
    end

    // CSR storage registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtvec_q    <= MTVEC_INIT;
            mscratch_q <= 64'h0;
            mepc_q     <= 64'h0;
            mcause_q   <= 64'h0;
            mcycle_q   <= 64'h0;
        end else begin
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    // Combinational read from current state; same-cycle writes are not forwarded
    always_comb begin
        bus.csr_rd_data = 64'h0;
        case (bus.csr_rd_addr)
            CSR_MSTATUS:  bus.csr_rd_data = mstatus;
            CSR_MTVEC:    bus.csr_rd_data = mtvec_q;
            CSR_MSCRATCH: bus.csr_rd_data = mscratch_q;
            CSR_MEPC:     bus.csr_rd_data = mepc_q;
            CSR_MCAUSE:   bus.csr_rd_data = mcause_q;
            CSR_MCYCLE:   bus.csr_rd_data = mcycle_q;
            CSR_MHARTID:  bus.csr_rd_data = HART_ID;
            default:      bus.csr_rd_data = 64'h0;
        endcase
    end

    assign bus.csr_illegal = !csr_supported(bus.csr_rd_addr) || (bus.csr_wr_en && !wr_legal);

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - randomized self-checking bench for csr_trap_unit
module tb_csr_trap_unit;

    localparam logic [63:0] MTVEC_RST = 64'h8000_0003;
    localparam logic [63:0] HART      = 64'h2A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_trap_unit_if ifc ();

    csr_trap_unit #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_rpc;
    logic        m_rv;

    logic [63:0] obs_rd, obs_rpc;
    logic        obs_ill, obs_rv;

    logic [11:0] addr_tbl [8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'hB00, 12'hF14, 12'h7C0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_known(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) ||
               (a == 12'h342) || (a == 12'hB00) || (a == 12'hF14);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle;
            12'hF14: return HART;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus  = 64'h0;
        m_mtvec    = MTVEC_RST & ~64'h3;
        m_mscratch = 64'h0;
        m_mepc     = 64'h0;
        m_mcause   = 64'h0;
        m_mcycle   = 64'h0;
        m_rv       = 1'b0;
        m_rpc      = 64'h0;
    endtask

    // One clock cycle: drive, check combinational and registered outputs, advance model
    task automatic tick(input bit rn, input logic [11:0] ra, input bit we,
                        input logic [11:0] wa, input logic [63:0] wd,
                        input bit ec, input bit mr, input logic [63:0] p);
        logic [63:0] old_mtvec, old_mepc;
        bit          mie, mpie, wl, exp_ill;
        rst             = rn;
        ifc.csr_rd_addr = ra;
        ifc.csr_wr_en   = we;
        ifc.csr_wr_addr = wa;
        ifc.csr_wr_data = wd;
        ifc.ecall_valid = ec;
        ifc.mret_valid  = mr;
        ifc.pc          = p;
        #1;
        wl      = m_known(wa) && (wa[11:10] != 2'b11);
        exp_ill = !m_known(ra) || (we && !wl);
        obs_rd  = ifc.csr_rd_data;
        obs_ill = ifc.csr_illegal;
        obs_rv  = ifc.redirect_valid;
        obs_rpc = ifc.redirect_pc;
        check("rd_data", obs_rd, m_read(ra));
        check("csr_illegal", obs_ill, exp_ill);
        check("redirect_valid", obs_rv, m_rv);
        check("redirect_pc", obs_rpc, m_rpc);
        @(posedge clk);
        old_mtvec = m_mtvec;
        old_mepc  = m_mepc;
        mie       = m_mstatus[3];
        mpie      = m_mstatus[7];
        if (!rn) begin
            model_reset();
        end else begin
            m_rv     = 1'b0;
            m_mcycle = m_mcycle + 64'd1;
            if (ec) begin
                m_mepc    = {p[63:1], 1'b0};
                m_mcause  = 64'd11;
                m_mstatus = 64'h1800 | (mie ? 64'h80 : 64'h0);
                m_rv      = 1'b1;
                m_rpc     = old_mtvec;
            end else if (mr) begin
                m_mstatus = 64'h80 | (mpie ? 64'h8 : 64'h0);
                m_rv      = 1'b1;
                m_rpc     = old_mepc;
            end else if (we && wl) begin
                case (wa)
                    12'h300: m_mstatus  = wd & 64'h1888;
                    12'h305: m_mtvec    = wd & ~64'h3;
                    12'h340: m_mscratch = wd;
                    12'h341: m_mepc     = wd & ~64'h1;
                    12'h342: m_mcause   = wd;
                    12'hB00: m_mcycle   = wd;
                    default: ;
                endcase
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [11:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return addr_tbl[r];
        return 12'($urandom);
    endfunction

    initial begin
        rst             = 1'b0;
        ifc.csr_rd_addr = 12'h0;
        ifc.csr_wr_en   = 1'b0;
        ifc.csr_wr_addr = 12'h0;
        ifc.csr_wr_data = 64'h0;
        ifc.ecall_valid = 1'b0;
        ifc.mret_valid  = 1'b0;
        ifc.pc          = 64'h0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state
        tick(1, 12'h305, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("reset_mtvec", obs_rd, 64'h8000_0000);
        check("reset_redirect", obs_rv, 1'b0);
        tick(1, 12'h341, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("reset_mepc", obs_rd, 64'h0);

        // Write/readback and illegal accesses
        tick(1, 12'h0, 1, 12'h340, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'h0);
        tick(1, 12'h340, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("mscratch_rb", obs_rd, 64'hDEAD_BEEF_0123_4567);
        tick(1, 12'hF14, 1, 12'hF14, 64'h5, 0, 0, 64'h0);
        check("mhartid_wr_illegal", obs_ill, 1'b1);
        tick(1, 12'hF14, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("mhartid_ro", obs_rd, HART);
        tick(1, 12'h7C0, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("unsup_rd_data", obs_rd, 64'h0);
        check("unsup_rd_illegal", obs_ill, 1'b1);

        // ecall
        tick(1, 12'h0, 1, 12'h305, 64'h8000_1000, 0, 0, 64'h0);
        tick(1, 12'h0, 1, 12'h300, 64'h8, 0, 0, 64'h0);
        tick(1, 12'h300, 0, 12'h0, 64'h0, 1, 0, 64'h8000_0204);
        tick(1, 12'h341, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("ecall_rv", obs_rv, 1'b1);
        check("ecall_rpc", obs_rpc, 64'h8000_1000);
        check("ecall_mepc", obs_rd, 64'h8000_0204);
        tick(1, 12'h342, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("ecall_mcause", obs_rd, 64'd11);
        check("ecall_pulse_end", obs_rv, 1'b0);
        tick(1, 12'h300, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("ecall_mstatus", obs_rd, 64'h1880);

        // mret
        tick(1, 12'h0, 0, 12'h0, 64'h0, 0, 1, 64'h8000_1010);
        tick(1, 12'h300, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("mret_rv", obs_rv, 1'b1);
        check("mret_rpc", obs_rpc, 64'h8000_0204);
        check("mret_mstatus", obs_rd, 64'h88);

        // Simultaneous ecall + mret + write
        tick(1, 12'h0, 1, 12'h340, 64'h7, 1, 1, 64'h8000_0301);
        tick(1, 12'h340, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("simul_mscratch", obs_rd, 64'hDEAD_BEEF_0123_4567);
        check("simul_rpc", obs_rpc, 64'h8000_1000);
        tick(1, 12'h300, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("simul_mstatus", obs_rd, 64'h1880);
        tick(1, 12'h341, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("simul_mepc", obs_rd, 64'h8000_0300);

        // mcycle wrap
        tick(1, 12'h0, 1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h0);
        tick(1, 12'hB00, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("mcycle_load", obs_rd, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(1, 12'hB00, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("mcycle_max", obs_rd, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1, 12'hB00, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("mcycle_wrap", obs_rd, 64'h0);

        // Reset during the redirect cycle, and reset in the ecall cycle itself
        tick(1, 12'h0, 0, 12'h0, 64'h0, 1, 0, 64'h8000_0400);
        tick(0, 12'h0, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        tick(1, 12'h0, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("rst_mid_rv", obs_rv, 1'b0);
        check("rst_mid_rpc", obs_rpc, 64'h0);
        tick(0, 12'h0, 1, 12'h340, 64'h9, 1, 0, 64'h8000_0500);
        tick(1, 12'h340, 0, 12'h0, 64'h0, 0, 0, 64'h0);
        check("rst_ecall_rv", obs_rv, 1'b0);
        check("rst_ecall_wr", obs_rd, 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] wa;
            logic [63:0] wd;
            wa = pick_addr();
            wd = {$urandom, $urandom};
            tick(($urandom_range(0, 49) != 0), pick_addr(), ($urandom_range(0, 2) == 0),
                 wa, wd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
